// File: rtl/cache_refill_controller.sv
// Hit-lookup / burst-refill sequencer for a direct-mapped cache, with refill timeout.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module cache_refill_controller #(
    parameter int unsigned LINE_WORDS     = 4,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned STAT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              miss,
    input  logic              memAck,
    output logic              memRead,
    output logic [IDX_W-1:0]  wordIdx,
    output logic              regWrite,
    output logic              tagWrite,
    output logic              outSel,
    output logic              outDataReady,
    output logic              increment,
    output logic              memError,
    output logic [STAT_W-1:0] hitCount,
    output logic [STAT_W-1:0] missCount
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_REFILL, S_UPDATE, S_RESPOND, S_ERROR
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   word_idx, word_idx_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               refilled, refilled_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            word_idx <= '0;
            timer    <= '0;
            refilled <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_idx <= word_idx_nxt;
            timer    <= timer_nxt;
            refilled <= refilled_nxt;
        end
    end

    // Next-state logic; timer counts consecutive ack-less refill cycles.
    always_comb begin
        state_nxt    = state;
        word_idx_nxt = word_idx;
        timer_nxt    = timer;
        refilled_nxt = refilled;
        case (state)
            S_IDLE: begin
                if (reqValid) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (miss) begin
                    state_nxt    = S_REFILL;
                    word_idx_nxt = '0;
                    timer_nxt    = '0;
                end else begin
                    state_nxt    = S_RESPOND;
                    refilled_nxt = 1'b0;
                end
            end
            S_REFILL: begin
                if (memAck) begin
                    timer_nxt = '0;
                    if (word_idx == LAST_IDX) begin
                        word_idx_nxt = '0;
                        state_nxt    = S_UPDATE;
                    end else begin
                        word_idx_nxt = word_idx + IDX_W'(1);
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (timer == TMR_LAST)) begin
                    timer_nxt    = '0;
                    word_idx_nxt = '0;
                    state_nxt    = S_ERROR;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            S_UPDATE: begin
                refilled_nxt = 1'b1;
                state_nxt    = S_RESPOND;
            end
            S_RESPOND: state_nxt = S_IDLE;
            S_ERROR:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs from registered state; regWrite alone follows memAck directly.
    assign reqReady     = (state == S_IDLE);
    assign memRead      = (state == S_REFILL);
    assign regWrite     = (state == S_REFILL) && memAck;
    assign wordIdx      = word_idx;
    assign tagWrite     = (state == S_UPDATE);
    assign outDataReady = (state == S_RESPOND);
    assign increment    = (state == S_RESPOND);
    assign outSel       = (state == S_RESPOND) && refilled;
    assign memError     = (state == S_ERROR);

`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] hit_cnt, miss_cnt;
    logic              hit_evt, miss_evt;

    assign hit_evt  = (state == S_LOOKUP) && !miss;
    assign miss_evt = (state == S_LOOKUP) && miss;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_evt && (hit_cnt != '1))   hit_cnt  <= hit_cnt + STAT_W'(1);
            if (miss_evt && (miss_cnt != '1)) miss_cnt <= miss_cnt + STAT_W'(1);
        end
    end

    assign hitCount  = hit_cnt;
    assign missCount = miss_cnt;
`else
    assign hitCount  = '0;
    assign missCount = '0;
`endif

endmodule

// File: tb/tb_cache_refill_controller.sv
// Self-checking bench for cache_refill_controller: directed and random hit/miss/timeout traffic
// compared cycle by cycle against a transaction-level expectation model.
module tb_cache_refill_controller;

    localparam int unsigned LW  = 4;
    localparam int unsigned IW  = 2;
    localparam int unsigned TO  = 16;
    localparam int unsigned SW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          reqValid, reqReady, miss, memAck, memRead;
    logic [IW-1:0] wordIdx;
    logic          regWrite, tagWrite, outSel, outDataReady, increment, memError;
    logic [SW-1:0] hitCount, missCount;

    int n_assert = 0;
    int n_fail   = 0;
    int m_hits   = 0;
    int m_misses = 0;
    int gaps[LW];

    cache_refill_controller #(
        .LINE_WORDS(LW), .IDX_W(IW), .TIMEOUT_CYCLES(TO), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .miss(miss),
        .memAck(memAck), .memRead(memRead), .wordIdx(wordIdx), .regWrite(regWrite),
        .tagWrite(tagWrite), .outSel(outSel), .outDataReady(outDataReady),
        .increment(increment), .memError(memError), .hitCount(hitCount), .missCount(missCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] stat_exp(input int n);
`ifdef CACHE_STATS_EN
        return (n > 3) ? 32'd3 : 32'(n);
`else
        return (n < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input bit rr, input bit mr, input bit rw,
                              input bit tw, input bit os, input bit odr, input bit inc,
                              input bit me, input int wi);
        check({tag, ".reqReady"},     32'(reqReady),     32'(rr));
        check({tag, ".memRead"},      32'(memRead),      32'(mr));
        check({tag, ".regWrite"},     32'(regWrite),     32'(rw));
        check({tag, ".tagWrite"},     32'(tagWrite),     32'(tw));
        check({tag, ".outSel"},       32'(outSel),       32'(os));
        check({tag, ".outDataReady"}, 32'(outDataReady), 32'(odr));
        check({tag, ".increment"},    32'(increment),    32'(inc));
        check({tag, ".memError"},     32'(memError),     32'(me));
        check({tag, ".wordIdx"},      32'(wordIdx),      32'(wi));
        check({tag, ".hitCount"},     32'(hitCount),     stat_exp(m_hits));
        check({tag, ".missCount"},    32'(missCount),    stat_exp(m_misses));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_and_lookup(input string tag, input bit is_miss);
        reqValid = 1'b1; miss = 1'($urandom); memAck = 1'($urandom);
        #1 expect_all({tag, ".idle"}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        reqValid = 1'($urandom); miss = is_miss; memAck = 1'($urandom);
        #1 expect_all({tag, ".lookup"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        if (is_miss) m_misses++; else m_hits++;
    endtask

    task automatic run_hit();
        idle_and_lookup("hit", 1'b0);
        reqValid = 1'b0; miss = 1'($urandom); memAck = 1'($urandom);
        #1 expect_all("hit.respond", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc();
    endtask

    // Words arrive after gaps[w] idle cycles; 16 consecutive idle cycles abort the refill.
    task automatic run_miss(input string tag);
        int  w, idle, g;
        bit  ack, err;
        idle_and_lookup(tag, 1'b1);
        w = 0; idle = 0; g = gaps[0]; err = 0;
        for (int c = 0; c < 200; c++) begin
            ack = (g == 0);
            memAck = ack; reqValid = 1'($urandom); miss = 1'($urandom);
            #1 expect_all({tag, ".refill"}, 0, 1, ack, 0, 0, 0, 0, 0, w);
            cyc();
            if (ack) begin
                w++; idle = 0;
                if (w == LW) break;
                g = gaps[w];
            end else begin
                idle++; g--;
                if (idle == TO) begin err = 1; break; end
            end
        end
        memAck = 1'($urandom); reqValid = 1'b0;
        if (err) begin
            #1 expect_all({tag, ".error"}, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            cyc();
        end else begin
            #1 expect_all({tag, ".update"}, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            cyc();
            memAck = 1'($urandom);
            #1 expect_all({tag, ".respond"}, 0, 0, 0, 0, 1, 1, 1, 0, 0);
            cyc();
        end
        memAck = 1'b0;
        #1 expect_all({tag, ".back_idle"}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; reqValid = 1'b0; miss = 1'b0; memAck = 1'b0;
        repeat (2) @(negedge clk);
        #1 expect_all("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // five hits then one back-to-back miss exercises counter saturation
        for (int i = 0; i < 5; i++) run_hit();
        gaps = '{0, 0, 0, 0};
        run_miss("miss_b2b");

        gaps = '{2, 2, 2, 2};
        run_miss("miss_gap3");

        gaps = '{15, 0, 15, 15};
        run_miss("miss_ack_at_expiry");

        gaps = '{1, 99, 0, 0};
        run_miss("timeout_mid");

        gaps = '{99, 99, 99, 99};
        run_miss("timeout");

        // reset during refill after the second word
        idle_and_lookup("rst_mid", 1'b1);
        for (int k = 0; k < 2; k++) begin
            memAck = 1'b1; reqValid = 1'b0;
            #1 expect_all("rst_mid.refill", 0, 1, 1, 0, 0, 0, 0, 0, k);
            cyc();
        end
        memAck = 1'b0;
        #1 expect_all("rst_mid.pre", 0, 1, 0, 0, 0, 0, 0, 0, 2);
        rst = 1'b1;
        m_hits = 0; m_misses = 0;
        #1 expect_all("rst_mid.async", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;
        gaps = '{0, 1, 0, 2};
        run_miss("after_rst");

        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_hit();
            end else begin
                for (int k = 0; k < int'(LW); k++) gaps[k] = int'($urandom_range(0, 17));
                run_miss("rand_miss");
            end
        end

        #1 expect_all("final", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_refill_controller.md
Name: cache_refill_controller

Overview:
- Parametrised successor to the single-word cache control FSM: sequences hit lookups and multi-word line refills for a direct-mapped cache.
- Sits between the request/address stage, the cache data/tag arrays and the main-memory port.
- Adds a request handshake, burst refill with word counter, refill timeout with error reporting, and a separate tag-update step.

Parameters:
- LINE_WORDS, 4, words per cache line fetched per refill; power of two, >=1
- IDX_W, 2, width of wordIdx; equals max(1, log2(LINE_WORDS))
- TIMEOUT_CYCLES, 16, max idle cycles waiting for memAck in REFILL; 0 disables timeout
- STAT_W, 16, width of statistics counters

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- reqValid  input  1  address stage presents a request
- reqReady  output  1  controller accepts a request (IDLE)
- miss  input  1  tag compare result, valid in LOOKUP
- memAck  input  1  memory word valid this cycle
- memRead  output  1  memory read request, held through REFILL
- wordIdx  output  IDX_W  word index within line being written
- regWrite  output  1  write current memory word into data array
- tagWrite  output  1  write tag and set valid bit
- outSel  output  1  0 = cache data path, 1 = refilled-line path
- outDataReady  output  1  response data valid
- increment  output  1  advance requester address
- memError  output  1  refill aborted by timeout
- hitCount  output  STAT_W  hits counted (see Optional Feature)
- missCount  output  STAT_W  misses counted (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- States: IDLE, LOOKUP, REFILL, UPDATE, RESPOND, ERROR.
- Reset: state IDLE, wordIdx 0, timeout counter 0, refilled flag 0, stats 0. All outputs 0 except reqReady=1.
- IDLE: reqReady=1. reqValid=1 -> LOOKUP; else stay.
- LOOKUP: miss=0 -> RESPOND with refilled=0. miss=1 -> REFILL with wordIdx=0, timer=0.
- REFILL:
  - memRead=1.
  - regWrite = memAck (Mealy, same cycle); wordIdx increments on each memAck.
  - memAck with wordIdx==LINE_WORDS-1 -> UPDATE, wordIdx wraps to 0.
  - Timer counts cycles without memAck and clears on memAck. Timer reaching TIMEOUT_CYCLES (when nonzero) -> ERROR.
  - memAck in the same cycle as expiry: the ack wins and the timer clears.
- UPDATE: tagWrite=1 for exactly one cycle, refilled=1 -> RESPOND.
- RESPOND: outDataReady=1, increment=1, outSel=refilled, one cycle -> IDLE.
- ERROR: memError=1 for one cycle, no tagWrite, no outDataReady, no increment -> IDLE. The line stays invalid.
- All outputs except regWrite are Moore-decoded from registered state/flags.
- Latency:
  - Hit: 3 cycles from reqValid sampled to outDataReady (IDLE->LOOKUP->RESPOND).
  - Miss: LOOKUP + refill cycles + UPDATE + RESPOND.
- memAck outside REFILL is ignored. reqValid outside IDLE is ignored.
- LINE_WORDS=1: single memAck goes directly to UPDATE; wordIdx stays 0.
- rst asserted mid-refill: immediate return to IDLE, memRead drops asynchronously, no tagWrite.

Optional Feature:
- Macro: CACHE_STATS_EN
- Defined:
  - hitCount increments on each LOOKUP->RESPOND.
  - missCount increments on each LOOKUP->REFILL.
  - Both saturate at 2^STAT_W-1 and clear on rst.
- Undefined: no counter registers; hitCount and missCount tied to 0; all other behaviour identical.

Test Plan:
- Hit (LINE_WORDS=4): reqValid=1 one cycle, miss=0 in LOOKUP -> outDataReady=1, increment=1, outSel=0 on 3rd cycle; no memRead; back to reqReady=1.
- Miss with back-to-back acks: miss=1, memAck high 4 consecutive cycles -> regWrite 4 cycles, wordIdx 0,1,2,3; tagWrite next cycle; then outDataReady=1 with outSel=1.
- Miss with gaps: memAck every 3rd cycle -> memRead held throughout, regWrite only on ack cycles, exactly 4 writes, no memError.
- Timeout (TIMEOUT_CYCLES=16): miss=1, memAck never asserted -> memError=1 one cycle after 16 idle cycles; no tagWrite; IDLE next.
- Reset mid-refill: assert rst after 2nd ack -> memRead=0 and wordIdx=0 immediately; reqReady=1; after release, a new miss refills from wordIdx 0.
- Stats (CACHE_STATS_EN, STAT_W=2): 5 hits, 1 miss -> hitCount=3 (saturated), missCount=1; without macro both read 0.
